// File: rtl/ipsl_pcie_tlp_pkg.sv
// TLP field codes, completion status codes, header bit positions and the
// DW byte-swap helper shared by the config completer and initiator logic.
package ipsl_pcie_tlp_pkg;

    // fmt codes for 3-DW headers
    localparam logic [2:0] FMT_NODATA = 3'b000;
    localparam logic [2:0] FMT_DATA   = 3'b010;

    // type codes
    localparam logic [4:0] TYPE_CFG0  = 5'b00100;
    localparam logic [4:0] TYPE_CFG1  = 5'b00101;
    localparam logic [4:0] TYPE_CPL   = 5'b01010;

    // completion status codes
    localparam logic [2:0] CPL_SC     = 3'b000;
    localparam logic [2:0] CPL_UR     = 3'b001;

    // request header field LSB positions inside the 128-bit header beat
    localparam int FMT_LSB    = 29;
    localparam int TYPE_LSB   = 24;
    localparam int LEN_LSB    = 0;
    localparam int REQID_LSB  = 48;
    localparam int TAG_LSB    = 40;
    localparam int FBE_LSB    = 32;
    localparam int REGNUM_LSB = 66;

    // The core presents payload DWs big-endian; swap bytes 0<->3 and 1<->2.
    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/ipsl_pcie_cpl_hdr_gen.sv
// Combinational builder for a 3-DW Cpl/CplD header in the 128-bit beat layout.
module ipsl_pcie_cpl_hdr_gen
    import ipsl_pcie_tlp_pkg::*;
(
    input  logic [15:0]  completer_id_i,
    input  logic [2:0]   status_i,
    input  logic [15:0]  req_id_i,
    input  logic [7:0]   tag_i,
    input  logic [11:0]  byte_cnt_i,
    input  logic         with_data_i,
    output logic [127:0] hdr_o
);

    // DW0: fmt, type, length 1
    assign hdr_o[31:0]   = {(with_data_i ? FMT_DATA : FMT_NODATA), TYPE_CPL, 14'h0, 10'd1};
    // DW1: completer ID, status, BCM=0, byte count
    assign hdr_o[63:32]  = {completer_id_i, status_i, 1'b0, byte_cnt_i};
    // DW2: requester ID, tag, reserved bit, lower address 0
    assign hdr_o[95:64]  = {req_id_i, tag_i, 1'b0, 7'h00};
    // DW3 unused in a 3-DW header
    assign hdr_o[127:96] = 32'h0;

endmodule

// File: rtl/ipsl_pcie_cfg_responder.sv
// Completer for CfgRd0/CfgWr0 TLPs: performs single-DW accesses on a local
// register space and returns Cpl/CplD, answering CfgRd1/CfgWr1 and
// malformed type-0 requests with UR completions.
module ipsl_pcie_cfg_responder
    import ipsl_pcie_tlp_pkg::*;
#(
    parameter logic [11:0] CPL_BYTE_CNT = 12'd4
) (
    input  logic         pclk_div2,
    input  logic         apb_rst_n,
    input  logic [15:0]  completer_id,
    input  logic         axis_master_tvalid,
    input  logic         axis_master_tlast,
    input  logic [3:0]   axis_master_tkeep,
    input  logic [127:0] axis_master_tdata,
    output logic         axis_master_tready,
    input  logic         axis_slave_tready,
    output logic         axis_slave_tvalid,
    output logic         axis_slave_tlast,
    output logic         axis_slave_tuser,
    output logic [127:0] axis_slave_tdata,
    output logic [9:0]   cfg_reg_addr,
    output logic [3:0]   cfg_reg_be,
    output logic         cfg_reg_wr,
    output logic         cfg_reg_rd,
    output logic [31:0]  cfg_reg_wdata,
    input  logic [31:0]  cfg_reg_rdata,
    output logic [7:0]   ur_cnt
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_WDAT    = 4'd1;
    localparam logic [3:0] S_WR      = 4'd2;
    localparam logic [3:0] S_RD      = 4'd3;
    localparam logic [3:0] S_RCAP    = 4'd4;
    localparam logic [3:0] S_UR_WAIT = 4'd5;
    localparam logic [3:0] S_DROP    = 4'd6;
    localparam logic [3:0] S_CPL     = 4'd7;
    localparam logic [3:0] S_CPLD_H  = 4'd8;
    localparam logic [3:0] S_CPLD_D  = 4'd9;

    logic [3:0]   state_q,  state_d;
    logic [9:0]   addr_q,   addr_d;
    logic [3:0]   be_q,     be_d;
    logic [31:0]  wdata_q,  wdata_d;
    logic [31:0]  rdata_q,  rdata_d;
    logic [15:0]  req_id_q, req_id_d;
    logic [7:0]   tag_q,    tag_d;
    logic [2:0]   status_q, status_d;
    logic [7:0]   ur_cnt_q, ur_cnt_d;
    logic         ur_inc;

    // Header field decode of the current RX beat
    logic [2:0]   hdr_fmt;
    logic [4:0]   hdr_type;
    logic [9:0]   hdr_len;
    logic [15:0]  hdr_req_id;
    logic [7:0]   hdr_tag;
    logic [3:0]   hdr_fbe;
    logic [9:0]   hdr_reg_num;
    logic         hdr_cfg0, hdr_len_one;
    logic         hdr_is_rd, hdr_is_wr, hdr_is_ur;
    logic         rx_hs, tx_hs;
    logic         accept_state;
    logic [127:0] cpl_hdr;

    assign hdr_fmt     = axis_master_tdata[FMT_LSB +: 3];
    assign hdr_type    = axis_master_tdata[TYPE_LSB +: 5];
    assign hdr_len     = axis_master_tdata[LEN_LSB +: 10];
    assign hdr_req_id  = axis_master_tdata[REQID_LSB +: 16];
    assign hdr_tag     = axis_master_tdata[TAG_LSB +: 8];
    assign hdr_fbe     = axis_master_tdata[FBE_LSB +: 4];
    assign hdr_reg_num = axis_master_tdata[REGNUM_LSB +: 10];

    assign hdr_cfg0    = (hdr_type == TYPE_CFG0);
    assign hdr_len_one = (hdr_len == 10'd1);
    assign hdr_is_rd   = hdr_cfg0 && hdr_len_one && (hdr_fmt == FMT_NODATA);
    // A write header that already carries tlast has no data beat: reject as UR.
    assign hdr_is_wr   = hdr_cfg0 && hdr_len_one && (hdr_fmt == FMT_DATA) && !axis_master_tlast;
    assign hdr_is_ur   = (hdr_type == TYPE_CFG1) || (hdr_cfg0 && !hdr_is_rd && !hdr_is_wr);

    // Bits of the RX beat that carry no meaning for this completer
    logic unused_rx;
    assign unused_rx = ^{axis_master_tkeep, axis_master_tdata[127:76], axis_master_tdata[65:64],
                         axis_master_tdata[39:36], axis_master_tdata[23:10]};

    assign accept_state = (state_q == S_IDLE) || (state_q == S_WDAT) ||
                          (state_q == S_UR_WAIT) || (state_q == S_DROP);
    // Held low while reset is asserted so nothing is taken before the FSM is known
    assign axis_master_tready = apb_rst_n && accept_state;
    assign rx_hs = axis_master_tvalid && axis_master_tready;
    assign tx_hs = axis_slave_tvalid && axis_slave_tready;

    ipsl_pcie_cpl_hdr_gen u_cpl_hdr_gen (
        .completer_id_i (completer_id),
        .status_i       (status_q),
        .req_id_i       (req_id_q),
        .tag_i          (tag_q),
        .byte_cnt_i     (CPL_BYTE_CNT),
        .with_data_i    (state_q != S_CPL),
        .hdr_o          (cpl_hdr)
    );

    // Next-state, field capture and UR accounting
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        req_id_d = req_id_q;
        tag_d    = tag_q;
        status_d = status_q;
        ur_inc   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_hs) begin
                    req_id_d = hdr_req_id;
                    tag_d    = hdr_tag;
                    status_d = hdr_is_ur ? CPL_UR : CPL_SC;
                    // Register address only moves for accesses that will strobe
                    if (hdr_is_rd || hdr_is_wr) begin
                        addr_d = hdr_reg_num;
                        be_d   = hdr_fbe;
                    end
                    if (hdr_is_rd) begin
                        state_d = S_RD;
                    end else if (hdr_is_wr) begin
                        state_d = S_WDAT;
                    end else if (hdr_is_ur) begin
                        if (axis_master_tlast) begin
                            state_d = S_CPL;
                            ur_inc  = 1'b1;
                        end else begin
                            state_d = S_UR_WAIT;
                        end
                    end else if (!axis_master_tlast) begin
                        state_d = S_DROP;
                    end
                end
            end
            S_WDAT: begin
                if (rx_hs) begin
                    wdata_d = bswap32(axis_master_tdata[31:0]);
                    state_d = S_WR;
                end
            end
            S_WR:   state_d = S_CPL;
            S_RD:   state_d = S_RCAP;
            S_RCAP: begin
                rdata_d = cfg_reg_rdata;
                state_d = S_CPLD_H;
            end
            S_UR_WAIT: begin
                if (rx_hs && axis_master_tlast) begin
                    state_d = S_CPL;
                    ur_inc  = 1'b1;
                end
            end
            S_DROP: begin
                if (rx_hs && axis_master_tlast) begin
                    state_d = S_IDLE;
                end
            end
            S_CPL:    if (tx_hs) state_d = S_IDLE;
            S_CPLD_H: if (tx_hs) state_d = S_CPLD_D;
            S_CPLD_D: if (tx_hs) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        ur_cnt_d = (ur_inc && (ur_cnt_q != 8'hFF)) ? ur_cnt_q + 8'd1 : ur_cnt_q;
    end

    // State and captured-field registers; reset abandons any completion in flight
    always_ff @(posedge pclk_div2) begin
        if (!apb_rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            req_id_q <= '0;
            tag_q    <= '0;
            status_q <= CPL_SC;
            ur_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            req_id_q <= req_id_d;
            tag_q    <= tag_d;
            status_q <= status_d;
            ur_cnt_q <= ur_cnt_d;
        end
    end

    assign cfg_reg_rd    = (state_q == S_RD);
    assign cfg_reg_wr    = (state_q == S_WR);
    assign cfg_reg_addr  = addr_q;
    assign cfg_reg_be    = be_q;
    assign cfg_reg_wdata = wdata_q;
    assign ur_cnt        = ur_cnt_q;

    // TX beat is a pure function of state, so it holds until handshake
    assign axis_slave_tvalid = (state_q == S_CPL) || (state_q == S_CPLD_H) || (state_q == S_CPLD_D);
    assign axis_slave_tlast  = (state_q == S_CPL) || (state_q == S_CPLD_D);
    assign axis_slave_tuser  = 1'b0;
    assign axis_slave_tdata  = (state_q == S_CPLD_D) ? {96'h0, bswap32(rdata_q)} :
                               ((state_q == S_CPL) || (state_q == S_CPLD_H)) ? cpl_hdr : 128'h0;

endmodule

// File: doc/ipsl_pcie_cfg_responder.md
# ipsl_pcie_cfg_responder

Completer side of the configuration-TLP path. Receives CfgRd0/CfgWr0 request TLPs from the PCIe core AXI-stream master (RX) interface, performs the access on a local 1024-DW register space, and returns Cpl/CplD TLPs on the AXI-stream slave (TX) interface. It sits on the endpoint-side `pclk_div2` domain beside the config-initiator logic and uses the same 128-bit header layout and data byte-swap convention.

## Interface
- `CPL_BYTE_CNT`, default 12'd4: byte-count field placed in every completion.
- `pclk_div2`  in  1  clock.
- `apb_rst_n`  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- `completer_id`  in  16  Bus/Dev/Fn inserted in completion DW1[63:48].
- `axis_master_tvalid`/`tlast`  in  1  RX request beat valid / last beat.
- `axis_master_tkeep`  in  4  RX DW enables; data beat uses bit 0 only.
- `axis_master_tdata`  in  128  RX beat.
- `axis_master_tready`  out  1  RX ready.
- `axis_slave_tready`  in  1  TX ready from core.
- `axis_slave_tvalid`/`tlast`  out  1  TX beat valid / last beat.
- `axis_slave_tuser`  out  1  tied 0.
- `axis_slave_tdata`  out  128  TX beat.
- `cfg_reg_addr`  out  10  DW register number.
- `cfg_reg_be`  out  4  first-DW byte enables.
- `cfg_reg_wr` / `cfg_reg_rd`  out  1  single-cycle access strobes.
- `cfg_reg_wdata`  out  32  write data.
- `cfg_reg_rdata`  in  32  read data, valid exactly 1 cycle after `cfg_reg_rd`.
- `ur_cnt`  out  8  saturating count of UR completions.

## Operation
- RX header fields: fmt [31:29], type [28:24], length [9:0], requester ID [63:48], tag [47:40], FBE [35:32], reg_num [75:66].
- Request classification on header beat: type 00100 and length 1 are supported. fmt 000 = CfgRd0. fmt 010 = CfgWr0. type 00101, or type 0010x with length ≠ 1, is Unsupported. Any other type is dropped.
- Write data is the second RX beat: `cfg_reg_wdata` = byte-swapped `tdata[31:0]`, i.e. bytes 0↔3 and 1↔2.
- FSM states:
  - IDLE: tready=1. On a header beat, capture fields. CfgRd0 → RD. CfgWr0 → WDAT. Unsupported → UR_WAIT, or CPL if the header beat has tlast. Other types → DROP, or stay in IDLE if tlast.
  - WDAT: tready=1. On a data beat → WR.
  - WR: pulse `cfg_reg_wr` → CPL, status 000.
  - RD: pulse `cfg_reg_rd` → RCAP.
  - RCAP: capture `cfg_reg_rdata` → CPLD_H.
  - UR_WAIT: tready=1. Consume beats until tlast; no register strobe. Then → CPL with status 001; `ur_cnt`+1, saturating at 255.
  - DROP: tready=1. Consume until tlast → IDLE.
  - CPL: single beat with tlast=1 → IDLE on handshake.
  - CPLD_H: header beat with tlast=0 → CPLD_D on handshake.
  - CPLD_D: data beat with tlast=1, `tdata` = {96'h0, byte-swapped read data} → IDLE on handshake.
- tready=0 in WR, RD, RCAP, CPL, CPLD_H and CPLD_D: one request outstanding at a time.
- Completion header:
  - DW0: fmt 000 (Cpl) or 010 (CplD), type 01010, length 1.
  - DW1: `completer_id`, status [47:45], BCM=0, byte count = `CPL_BYTE_CNT`.
  - DW2: requester ID [95:80], tag [79:72], lower address 0.
  - DW3: 0.

## Timing
- Reset (synchronous, sampled on the `pclk_div2` edge): FSM → IDLE; `axis_master_tready`=0 during reset and 1 from the first cycle after it. All other outputs are 0; `ur_cnt`=0. A completion in flight is abandoned and not resumed.
- CfgRd0, header accepted at edge k: `cfg_reg_rd` high in cycle k+1, rdata sampled at edge k+2, CplD header `tvalid` high from cycle k+3.
- CfgWr0, data beat accepted at edge k: `cfg_reg_wr` high in cycle k+1, Cpl `tvalid` high from cycle k+2.
- Strobes last exactly one cycle. `cfg_reg_addr`, `cfg_reg_be` and `cfg_reg_wdata` are stable from the strobe cycle until the next request.
- TX: `tvalid`, `tdata` and `tlast` hold until `tready`. `tvalid` never drops without a handshake; there is no bubble between CplD header and data beats when `tready` stays 1.
- A malformed write whose header beat has tlast=1 is treated as Unsupported: Cpl UR, no `cfg_reg_wr`.

## Structure
- Shared package `ipsl_pcie_tlp_pkg`: fmt/type codes, completion status codes (SC=000, UR=001), header field bit positions, byte-swap function; reused by the initiator-side logic.
- Sub-module `ipsl_pcie_cpl_hdr_gen` (combinational): builds the completion header from completer ID, status, requester ID, tag and byte count.

## Test plan
- CfgRd0, reg 0x010, tag 0x5A, req ID 0x0100, rdata 0x12345678 → `cfg_reg_rd` with addr 0x010 one cycle after the header; CplD DW2 = {0x0100, 0x5A, ...}, status 000; data beat `tdata[31:0]` = 0x78563412, tlast=1.
- CfgWr0, reg 0x004, FBE 0xF, data beat `tdata[31:0]` = 0xEFBEADDE → `cfg_reg_wr` with wdata 0xDEADBEEF and be 0xF; Cpl fmt 000, status 000, tlast on the single beat.
- CfgRd1 (type 00101), tag 0x11 → no register strobe; Cpl status 001, tag 0x11; `ur_cnt` = 1.
- CplD pending with `axis_slave_tready`=0 for 5 cycles → header beat held stable with tvalid=1; after release, the two beats go out on consecutive cycles.
- 3-beat MWr TLP → consumed with tready=1, no TX activity, no strobes.
- `apb_rst_n` low during CPLD_H → `tvalid`=0 after the reset edge; the next CfgRd completes normally.
